// File: rtl/pulse_sync_fast_tx.sv
// Source side of a fast-to-slow pulse crossing: turns single-cycle events into a
// 4-phase req/ack handshake and replays events that arrive mid-handshake in order.
module pulse_sync_fast_tx #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned PEND_W      = 4,
    parameter int unsigned TIMEOUT     = 1023
) (
    input  logic              clk_fast,
    input  logic              rst,
    input  logic              pulse_in,
    input  logic              ack_async,
    input  logic              err_clr,
    output logic              req_out,
    output logic              busy,
    output logic [PEND_W-1:0] pending,
    output logic              overflow,
    output logic              timeout_err
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_MAX   = TO_W'(TIMEOUT);
    localparam logic [TO_W-1:0]   TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        REL  = 2'd2
    } state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] ack_sync;
    logic [TO_W-1:0]        to_cnt;
    logic                   ack_s;

    assign ack_s = ack_sync[SYNC_STAGES-1];

    // Handshake FSM, pending-event queue counter, phase watchdog and sticky flags.
    always_ff @(posedge clk_fast) begin
        if (rst) begin
            state       <= IDLE;
            ack_sync    <= '0;
            to_cnt      <= '0;
            req_out     <= 1'b0;
            busy        <= 1'b0;
            pending     <= '0;
            overflow    <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            ack_sync <= {ack_sync[SYNC_STAGES-2:0], ack_async};

            // Clear first so a same-cycle set below takes priority.
            if (err_clr) begin
                overflow    <= 1'b0;
                timeout_err <= 1'b0;
            end

            if (state != IDLE && pulse_in) begin
                if (pending == PEND_MAX) begin
                    overflow <= 1'b1;
                end else begin
                    pending <= pending + PEND_W'(1);
                end
            end

            case (state)
                IDLE: begin
                    if (pulse_in || pending != '0) begin
                        state   <= REQ;
                        req_out <= 1'b1;
                        busy    <= 1'b1;
                        to_cnt  <= '0;
                        // A fresh pulse with a non-empty queue is a net zero change.
                        if (!pulse_in) begin
                            pending <= pending - PEND_W'(1);
                        end
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        state   <= REL;
                        req_out <= 1'b0;
                        to_cnt  <= '0;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + TO_W'(1);
                        if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        to_cnt <= '0;
                    end else if (to_cnt != TO_MAX) begin
                        to_cnt <= to_cnt + TO_W'(1);
                        if (to_cnt == TO_LAST) begin
                            timeout_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state   <= IDLE;
                    req_out <= 1'b0;
                    busy    <= 1'b0;
                    to_cnt  <= '0;
                end
            endcase
        end
    end

endmodule
